// File: rtl/fft_requant_stage.sv
// Inter-stage requantiser for the parallel FFT pipeline.
// Each component is rounded down by NSHIFT LSBs with a selectable rounding mode,
// then saturated to NBITS_OUT. The block forwards the enable with the data,
// marks frame starts, and reports per-frame saturation counts plus a sticky flag.
module fft_requant_stage #(
  parameter int NLANES    = 4,
  parameter int NBITS_IN  = 21,
  parameter int NBITS_OUT = 10,
  parameter int NSHIFT    = 11,
  parameter int N         = 128,
  parameter int CNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_enable,
  input  logic [1:0]                    i_round_mode,
  input  logic                          i_clr_flag,
  input  logic [NLANES*2*NBITS_IN-1:0]  i_data,
  output logic [NLANES*2*NBITS_OUT-1:0] o_data,
  output logic                          o_enable,
  output logic                          o_sof,
  output logic [CNT_W-1:0]              o_ovf_count,
  output logic                          o_ovf_flag
);

  localparam int NCOMP = 2 * NLANES;
  localparam int FRAME = N / NLANES;
  localparam int WX    = NBITS_IN + 1;
  localparam int FW    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int SW    = $clog2(NCOMP + 1);
  localparam int AW    = ((CNT_W > SW) ? CNT_W : SW) + 1;

  localparam logic signed [WX-1:0] YMAX = WX'(2 ** (NBITS_OUT - 1) - 1);
  localparam logic signed [WX-1:0] YMIN = WX'(-(2 ** (NBITS_OUT - 1)));
  localparam logic [AW-1:0]        CMAX = {{(AW - CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam logic [FW-1:0]        FLAST = FW'(FRAME - 1);

  if (N % NLANES != 0) begin : g_bad_frame
    $error("fft_requant_stage: N must be a multiple of NLANES");
  end
  if (NSHIFT >= NBITS_IN) begin : g_bad_shift
    $error("fft_requant_stage: NSHIFT must be below NBITS_IN");
  end

  typedef enum logic [1:0] {
    RM_TRUNC     = 2'b00,
    RM_HALF_UP   = 2'b01,
    RM_CONV      = 2'b10,
    RM_TRUNC_ALT = 2'b11
  } round_mode_t;

  round_mode_t rm;
  assign rm = round_mode_t'(i_round_mode);

  // Components are indexed by their position in the packed bus; input and
  // output use the same packing, so component c maps straight across.
  logic signed [WX-1:0] rnd [NCOMP];
  logic signed [WX-1:0] r_q [NCOMP];
  logic                 v1;

  if (NSHIFT == 0) begin : g_pass
    // No LSBs dropped: the rounding stage is a sign-extending pass-through.
    always_comb begin
      for (int unsigned c = 0; c < NCOMP; c++) begin
        rnd[c] = {i_data[c*NBITS_IN + NBITS_IN - 1], i_data[c*NBITS_IN +: NBITS_IN]};
      end
    end
  end else begin : g_round
    localparam logic signed [WX-1:0] HALF = WX'(1) << (NSHIFT - 1);
    logic signed [WX-1:0] xw   [NCOMP];
    logic signed [WX-1:0] bias [NCOMP];

    // Widen by one bit so adding the rounding bias can never overflow, then shift.
    always_comb begin
      for (int unsigned c = 0; c < NCOMP; c++) begin
        xw[c]   = {i_data[c*NBITS_IN + NBITS_IN - 1], i_data[c*NBITS_IN +: NBITS_IN]};
        bias[c] = '0;
        unique case (rm)
          RM_HALF_UP: bias[c] = HALF;
          RM_CONV:    bias[c] = HALF - WX'(1) + WX'(xw[c][NSHIFT]);
          default:    bias[c] = '0;
        endcase
        rnd[c] = (xw[c] + bias[c]) >>> NSHIFT;
      end
    end
  end

  // Stage 1 register: rounded components and their valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int unsigned c = 0; c < NCOMP; c++) r_q[c] <= '0;
    end else begin
      v1 <= in_enable;
      if (in_enable) begin
        for (int unsigned c = 0; c < NCOMP; c++) r_q[c] <= rnd[c];
      end
    end
  end

  logic [NLANES*2*NBITS_OUT-1:0] sat_word;
  logic [SW-1:0]                 sat_n;

  // Saturate each rounded component and count how many were clipped.
  always_comb begin
    sat_word = '0;
    sat_n    = '0;
    for (int unsigned c = 0; c < NCOMP; c++) begin
      if (r_q[c] > YMAX) begin
        sat_word[c*NBITS_OUT +: NBITS_OUT] = YMAX[NBITS_OUT-1:0];
        sat_n = sat_n + SW'(1);
      end else if (r_q[c] < YMIN) begin
        sat_word[c*NBITS_OUT +: NBITS_OUT] = YMIN[NBITS_OUT-1:0];
        sat_n = sat_n + SW'(1);
      end else begin
        sat_word[c*NBITS_OUT +: NBITS_OUT] = r_q[c][NBITS_OUT-1:0];
      end
    end
  end

  logic [SW-1:0] sat_q;

  // Stage 2 register: output word, its valid bit and its clip count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_enable <= 1'b0;
      o_data   <= '0;
      sat_q    <= '0;
    end else begin
      o_enable <= v1;
      sat_q    <= v1 ? sat_n : '0;
      if (v1) o_data <= sat_word;
    end
  end

  // Sticky saturation flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ovf_flag <= 1'b0;
    end else if (v1 && (sat_n != '0)) begin
      o_ovf_flag <= 1'b1;
    end else if (i_clr_flag) begin
      o_ovf_flag <= 1'b0;
    end
  end

  logic [FW-1:0]    fcnt;
  logic [CNT_W-1:0] acc;
  logic [AW-1:0]    acc_sum;
  logic [CNT_W-1:0] acc_sat;

  assign o_sof = o_enable && (fcnt == '0);

  // Running frame total including the word currently on the output.
  always_comb begin
    acc_sum = AW'(acc) + AW'(sat_q);
    acc_sat = (acc_sum > CMAX) ? '1 : acc_sum[CNT_W-1:0];
  end

  // Frame position and per-frame statistics, advanced on valid output words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt        <= '0;
      acc         <= '0;
      o_ovf_count <= '0;
    end else if (o_enable) begin
      if (fcnt == FLAST) begin
        fcnt        <= '0;
        acc         <= '0;
        o_ovf_count <= acc_sat;
      end else begin
        fcnt <= fcnt + FW'(1);
        acc  <= acc_sat;
      end
    end
  end

endmodule

// File: tb/tb_fft_requant_stage.sv
// Directed self-checking bench for fft_requant_stage (default parameters plus a
// CNT_W=3 instance for counter clipping).
module tb_fft_requant_stage;

  localparam int NL   = 4;
  localparam int BI   = 21;
  localparam int BO   = 10;
  localparam int DIW  = NL * 2 * BI;
  localparam int DOW  = NL * 2 * BO;
  localparam int SATV = 1047552;  // 511.5 output LSBs

  logic           clk = 1'b0;
  logic           rst;
  logic           in_enable;
  logic [1:0]     i_round_mode;
  logic           i_clr_flag;
  logic [DIW-1:0] i_data;
  logic [DOW-1:0] o_data, o_data3;
  logic           o_enable, o_enable3, o_sof, o_sof3, o_ovf_flag, o_ovf_flag3;
  logic [7:0]     o_ovf_count;
  logic [2:0]     o_ovf_count3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fft_requant_stage #(
    .NLANES(4), .NBITS_IN(21), .NBITS_OUT(10), .NSHIFT(11), .N(128), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .in_enable(in_enable), .i_round_mode(i_round_mode),
    .i_clr_flag(i_clr_flag), .i_data(i_data), .o_data(o_data), .o_enable(o_enable),
    .o_sof(o_sof), .o_ovf_count(o_ovf_count), .o_ovf_flag(o_ovf_flag)
  );

  fft_requant_stage #(
    .NLANES(4), .NBITS_IN(21), .NBITS_OUT(10), .NSHIFT(11), .N(128), .CNT_W(3)
  ) dut3 (
    .clk(clk), .rst(rst), .in_enable(in_enable), .i_round_mode(i_round_mode),
    .i_clr_flag(i_clr_flag), .i_data(i_data), .o_data(o_data3), .o_enable(o_enable3),
    .o_sof(o_sof3), .o_ovf_count(o_ovf_count3), .o_ovf_flag(o_ovf_flag3)
  );

  // Component c: lane c/2, odd = re, even = im.
  function automatic logic [DIW-1:0] in_comp(input logic [DIW-1:0] v, input int c, input int val);
    logic [BI-1:0] t;
    t = BI'(val);
    v[c*BI +: BI] = t;
    return v;
  endfunction

  function automatic logic [DOW-1:0] out_comp(input logic [DOW-1:0] v, input int c, input int val);
    logic [BO-1:0] t;
    t = BO'(val);
    v[c*BO +: BO] = t;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_enable = 1'b0; i_clr_flag = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one valid word; returns at the negedge where that word is on the output.
  task automatic send_one(input logic [1:0] mode, input logic [DIW-1:0] d);
    @(negedge clk);
    in_enable = 1'b1; i_round_mode = mode; i_data = d;
    @(negedge clk);
    in_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_flag();
    @(negedge clk);
    i_clr_flag = 1'b1;
    @(negedge clk);
    i_clr_flag = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_enable = 1'b1; i_clr_flag = 1'b0; i_round_mode = 2'b01;
    i_data = in_comp('0, 1, SATV);
    repeat (3) @(negedge clk);
    checks++;
    if (o_data !== '0 || o_enable !== 1'b0 || o_sof !== 1'b0 || o_ovf_count !== 8'd0 ||
        o_ovf_flag !== 1'b0 || o_ovf_count3 !== 3'd0) begin
      failures++;
      $display("FAIL reset: data=%0h en=%b sof=%b cnt=%0d flag=%b cnt3=%0d, required all 0",
               o_data, o_enable, o_sof, o_ovf_count, o_ovf_flag, o_ovf_count3);
    end
    in_enable = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_rounding();
    int        vals [8] = '{3072, 3072, 3072, -3072, -3072, -3072, 1024, 3072};
    logic [1:0] modes [8] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
    int        exps [8] = '{1, 2, 2, -2, -1, -2, 0, 1};
    logic [DOW-1:0] e;
    for (int i = 0; i < 8; i++) begin
      send_one(modes[i], in_comp('0, 1, vals[i]));
      e = out_comp('0, 1, exps[i]);
      checks++;
      if (o_enable !== 1'b1 || o_data !== e) begin
        failures++;
        $display("FAIL round[%0d] x=%0d mode=%0d: en=%b data=%0h, required en=1 data=%0h",
                 i, vals[i], modes[i], o_enable, o_data, e);
      end
    end
  endtask

  task automatic test_latency();
    logic en_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic oe_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   vals   [6] = '{5, 300, -7, 100, 0, 0};
    int   dexp   [6] = '{0, 0, 5, 5, -7, 100};
    logic [DOW-1:0] e;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_enable = en_pat[i]; i_round_mode = 2'b00; i_data = in_comp('0, 1, vals[i] * 2048);
      checks++;
      if (o_enable !== oe_exp[i]) begin
        failures++;
        $display("FAIL latency_en[%0d]: got %b required %b", i, o_enable, oe_exp[i]);
      end
      if (i >= 2) begin
        e = out_comp('0, 1, dexp[i]);
        checks++;
        if (o_data !== e) begin
          failures++;
          $display("FAIL latency_data[%0d]: got %0h required %0h", i, o_data, e);
        end
      end
    end
    @(negedge clk);
    in_enable = 1'b0;
  endtask

  task automatic test_saturation();
    logic [DOW-1:0] e;
    clear_flag();
    checks++;
    if (o_ovf_flag !== 1'b0) begin
      failures++; $display("FAIL flag_clear: got %b required 0", o_ovf_flag);
    end
    send_one(2'b00, in_comp('0, 1, SATV));
    e = out_comp('0, 1, 511);
    checks++;
    if (o_data !== e || o_ovf_flag !== 1'b0) begin
      failures++;
      $display("FAIL sat_trunc: data=%0h flag=%b required data=%0h flag=0", o_data, o_ovf_flag, e);
    end
    send_one(2'b01, in_comp('0, 1, SATV));
    checks++;
    if (o_data !== e || o_ovf_flag !== 1'b1) begin
      failures++;
      $display("FAIL sat_halfup: data=%0h flag=%b required data=%0h flag=1", o_data, o_ovf_flag, e);
    end
    clear_flag();
    send_one(2'b00, in_comp('0, 1, -1048576));
    e = out_comp('0, 1, -512);
    checks++;
    if (o_data !== e || o_ovf_flag !== 1'b0) begin
      failures++;
      $display("FAIL sat_min: data=%0h flag=%b required data=%0h flag=0", o_data, o_ovf_flag, e);
    end
  endtask

  task automatic test_frame_stats();
    logic [DIW-1:0] satw;
    logic [DOW-1:0] e;
    satw = in_comp(in_comp('0, 1, SATV), 6, SATV);
    e    = out_comp(out_comp('0, 1, 511), 6, 511);
    do_reset();
    for (int i = 0; i < 68; i++) begin
      @(negedge clk);
      if (i < 64) begin
        in_enable = 1'b1; i_round_mode = 2'b01;
        i_data = (i == 5 || i == 12 || i == 20) ? satw : '0;
      end else begin
        in_enable = 1'b0;
      end
      if (i == 2 || i == 34) begin
        checks++;
        if (o_sof !== 1'b1) begin failures++; $display("FAIL sof_first[%0d]: got %b required 1", i, o_sof); end
      end
      if (i == 3) begin
        checks++;
        if (o_sof !== 1'b0) begin failures++; $display("FAIL sof_second: got %b required 0", o_sof); end
      end
      if (i == 7) begin
        checks++;
        if (o_data !== e) begin failures++; $display("FAIL frame_satword: got %0h required %0h", o_data, e); end
      end
      if (i == 33) begin
        checks++;
        if (o_ovf_count !== 8'd0) begin failures++; $display("FAIL count_before_end: got %0d required 0", o_ovf_count); end
      end
      if (i == 34 || i == 50 || i == 65) begin
        checks++;
        if (o_ovf_count !== 8'd6) begin failures++; $display("FAIL count_frame1[%0d]: got %0d required 6", i, o_ovf_count); end
      end
      if (i == 66) begin
        checks++;
        if (o_ovf_count !== 8'd0) begin failures++; $display("FAIL count_clean_frame: got %0d required 0", o_ovf_count); end
      end
    end
  endtask

  task automatic test_counter_clip();
    logic [DIW-1:0] allsat;
    logic [DOW-1:0] e;
    allsat = '0;
    e      = '0;
    for (int c = 0; c < 2 * NL; c++) begin
      allsat = in_comp(allsat, c, SATV);
      e      = out_comp(e, c, 511);
    end
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_enable = (i < 32); i_round_mode = 2'b01; i_data = allsat;
      if (i == 2) begin
        checks++;
        if (o_data !== e) begin failures++; $display("FAIL clip_allsat_word: got %0h required %0h", o_data, e); end
      end
      if (i == 33) begin
        checks++;
        if (o_ovf_count3 !== 3'd0) begin failures++; $display("FAIL clip_before_end: got %0d required 0", o_ovf_count3); end
      end
      if (i == 34) begin
        checks++;
        if (o_ovf_count3 !== 3'd7) begin failures++; $display("FAIL clip_cnt3: got %0d required 7", o_ovf_count3); end
        checks++;
        if (o_ovf_count !== 8'd255) begin failures++; $display("FAIL clip_cnt8: got %0d required 255", o_ovf_count); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [DOW-1:0] e;
    // Count from the previous frame is 255 here; reset must clear it.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_enable = 1'b1; i_round_mode = 2'b01;
      i_data = (i == 2 || i == 3) ? in_comp(in_comp('0, 1, SATV), 4, SATV) : '0;
    end
    @(negedge clk);
    rst = 1'b1; i_data = in_comp('0, 1, SATV);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (o_data !== '0 || o_enable !== 1'b0 || o_sof !== 1'b0 || o_ovf_count !== 8'd0 || o_ovf_flag !== 1'b0) begin
        failures++;
        $display("FAIL midreset[%0d]: data=%0h en=%b sof=%b cnt=%0d flag=%b, required all 0",
                 i, o_data, o_enable, o_sof, o_ovf_count, o_ovf_flag);
      end
    end
    rst = 1'b0; in_enable = 1'b0;
    for (int j = 0; j < 36; j++) begin
      @(negedge clk);
      in_enable = (j < 32); i_round_mode = 2'b00; i_data = in_comp('0, 1, j * 2048);
      if (j == 2) begin
        checks++;
        if (o_sof !== 1'b1 || o_enable !== 1'b1) begin
          failures++; $display("FAIL post_reset_sof: sof=%b en=%b required 1,1", o_sof, o_enable);
        end
      end
      if (j == 3) begin
        e = out_comp('0, 1, 1);
        checks++;
        if (o_sof !== 1'b0 || o_data !== e) begin
          failures++; $display("FAIL post_reset_word1: sof=%b data=%0h required 0,%0h", o_sof, o_data, e);
        end
      end
      if (j == 34) begin
        checks++;
        if (o_ovf_count !== 8'd0 || o_ovf_flag !== 1'b0) begin
          failures++; $display("FAIL post_reset_count: cnt=%0d flag=%b required 0,0", o_ovf_count, o_ovf_flag);
        end
      end
    end
  endtask

  task automatic test_set_clear_collision();
    clear_flag();
    @(negedge clk);
    in_enable = 1'b1; i_round_mode = 2'b01; i_data = in_comp('0, 1, SATV);
    @(negedge clk);
    in_enable = 1'b0; i_clr_flag = 1'b1;
    @(negedge clk);
    i_clr_flag = 1'b0;
    checks++;
    if (o_ovf_flag !== 1'b1) begin failures++; $display("FAIL set_wins: got %b required 1", o_ovf_flag); end
    clear_flag();
    checks++;
    if (o_ovf_flag !== 1'b0) begin failures++; $display("FAIL clear_after_set: got %b required 0", o_ovf_flag); end
  endtask

  initial begin
    in_enable = 1'b0; i_clr_flag = 1'b0; i_round_mode = 2'b00; i_data = '0; rst = 1'b1;
    test_reset();
    test_rounding();
    test_latency();
    test_saturation();
    test_frame_stats();
    test_counter_clip();
    test_reset_midframe();
    test_set_clear_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
